sudoku_board_checker: RTL

Background validity checker for the 4x4 Sudoku datapath, directly upstream of the main FSM's `solved` input and gated by its `dp_check` output. Continuously snapshots the live board, scans the 12 groups (4 rows, 4 columns, 4 2x2 boxes) one per cycle, and presents a registered `solved` verdict. The verdict is valid whenever `ready` is high. Any board change restarts the scan.

---
 rtl/sudoku_pkg.sv | 34 +++
 rtl/sudoku_group_chk.sv | 34 +++
 rtl/sudoku_board_checker.sv | 106 ++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_pkg
// Description : Shared constants, FSM encoding and group-to-cell map for the
//               4x4 Sudoku board checker.
// Revision    : 1.0 - initial release
// ============================================================================
package sudoku_pkg;

    localparam int CELL_W = 3;
    localparam int N_GRP  = 12;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    // Cell index is {row, col}; groups 0-3 rows, 4-7 columns, 8-11 2x2 boxes.
    function automatic logic [3:0][3:0] grp_cells(input logic [3:0] grp);
        logic [3:0][3:0] cells;
        logic [1:0]      kk;
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            if (grp < 4'd4)
                cells[k] = {grp[1:0], kk};
            else if (grp < 4'd8)
                cells[k] = {kk, grp[1:0]};
            else
                cells[k] = {grp[1], kk[1], grp[0], kk[0]};
        end
        return cells;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sudoku_group_chk.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_group_chk
// Description : Combinational pass check for one 4-cell group: every digit
//               1..4 present exactly once, no empty or illegal cell.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_group_chk
    import sudoku_pkg::*;
(
    input  logic [4*CELL_W-1:0] cells,
    output logic                pass
);

    logic [3:0]        seen;
    logic              legal;
    logic [CELL_W-1:0] v;

    always_comb begin
        seen  = 4'd0;
        legal = 1'b1;
        v     = '0;
        for (int i = 0; i < 4; i++) begin
            v = cells[i*CELL_W +: CELL_W];
            if (v == '0 || v > CELL_W'(4))
                legal = 1'b0;
            else
                seen = seen | (4'd1 << (v - CELL_W'(1)));
        end
        pass = legal && (seen == 4'hF);
    end

endmodule
`default_nettype wire

// File: rtl/sudoku_board_checker.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_board_checker
// Description : Snapshots the live board and scans one group per cycle,
//               presenting a registered solved / fail_grp verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module sudoku_board_checker #(
    parameter int CELL_W = 3,
    parameter int N_GRP  = 12
) (
    input  logic                 clka,
    input  logic                 restart,
    input  logic [16*CELL_W-1:0] board,
    input  logic                 dp_check,
    output logic                 solved,
    output logic                 ready,
    output logic [3:0]           fail_grp,
    output logic                 chk_late
);

    import sudoku_pkg::*;

    logic [1:0]           state;
    logic [16*CELL_W-1:0] snap;
    logic [3:0]           grp_idx;
    logic [N_GRP-1:0]     pass_vec;

    logic [3:0][3:0]      cell_idx;
    logic [4*CELL_W-1:0]  grp_cells_val;
    logic                 grp_pass;
    logic [N_GRP-1:0]     pass_next;
    logic                 mismatch;

    function automatic logic [3:0] first_fail(input logic [N_GRP-1:0] pv);
        logic [3:0] idx;
        idx = 4'hF;
        for (int i = N_GRP - 1; i >= 0; i--)
            if (!pv[i]) idx = 4'(i);
        return idx;
    endfunction

    always_comb begin
        cell_idx      = grp_cells(grp_idx);
        grp_cells_val = '0;
        for (int k = 0; k < 4; k++)
            grp_cells_val[k*CELL_W +: CELL_W] = snap[32'(cell_idx[k])*CELL_W +: CELL_W];
    end

    sudoku_group_chk u_group_chk (
        .cells (grp_cells_val),
        .pass  (grp_pass)
    );

    // Folds the in-flight group into the vector so the final verdict sees it.
    assign pass_next = pass_vec | (N_GRP'(grp_pass) << grp_idx);
    assign mismatch  = (board != snap);

    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state    <= ST_INIT;
            snap     <= '0;
            grp_idx  <= 4'd0;
            pass_vec <= '0;
            solved   <= 1'b0;
            ready    <= 1'b0;
            fail_grp <= 4'hF;
            chk_late <= 1'b0;
        end else begin
            if (dp_check && !ready)
                chk_late <= 1'b1;

            case (state)
                ST_INIT: begin
                    snap     <= board;
                    grp_idx  <= 4'd0;
                    pass_vec <= '0;
                    state    <= ST_SCAN;
                end
                ST_SCAN, ST_VALID: begin
                    if (mismatch) begin
                        snap     <= board;
                        grp_idx  <= 4'd0;
                        pass_vec <= '0;
                        solved   <= 1'b0;
                        ready    <= 1'b0;
                        fail_grp <= 4'hF;
                        state    <= ST_SCAN;
                    end else if (state == ST_SCAN) begin
                        pass_vec <= pass_next;
                        grp_idx  <= grp_idx + 4'd1;
                        if (grp_idx == 4'(N_GRP - 1)) begin
                            state    <= ST_VALID;
                            ready    <= 1'b1;
                            solved   <= &pass_next;
                            fail_grp <= first_fail(pass_next);
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire
